// File: rtl/fp_norm_ctrl.sv
// Floating-point mantissa normalizer: leading-zero count, exponent-clamped left shift,
// and a valid/ready handshake around a four-state control FSM.

module fp_lshift #(
    parameter int SHIFTWIDTH = 5,
    parameter int DATAWIDTH  = 23
) (
    input  logic [DATAWIDTH-1:0]  val,
    input  logic [SHIFTWIDTH-1:0] count,
    output logic [DATAWIDTH-1:0]  result
);

    // Logarithmic barrel shifter: stage g shifts by 2**g when count[g] is set.
    logic [DATAWIDTH-1:0] stage [SHIFTWIDTH+1];

    assign stage[0] = val;

    for (genvar g = 0; g < SHIFTWIDTH; g++) begin : g_stage
        assign stage[g+1] = count[g] ? (stage[g] << (2**g)) : stage[g];
    end

    assign result = stage[SHIFTWIDTH];

endmodule

module fp_norm_ctrl #(
    parameter int DATAWIDTH  = 23,
    parameter int SHIFTWIDTH = 5,
    parameter int EXPWIDTH   = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [DATAWIDTH-1:0] in_mant,
    input  logic [EXPWIDTH-1:0]  in_exp,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DATAWIDTH-1:0] out_mant,
    output logic [EXPWIDTH-1:0]  out_exp,
    output logic                 out_zero,
    output logic                 out_denorm,
    output logic                 busy
);

    typedef enum logic [1:0] {IDLE, LZC, SHIFT, HOLD} state_t;

    state_t                state_q, state_d;

    logic [DATAWIDTH-1:0]  mant_q, mant_d;
    logic [EXPWIDTH-1:0]   exp_q, exp_d;
    logic [SHIFTWIDTH-1:0] sh_q, sh_d;
    logic                  denorm_q, denorm_d;
    logic                  zero_q, zero_d;

    logic [DATAWIDTH-1:0]  out_mant_q, out_mant_d;
    logic [EXPWIDTH-1:0]   out_exp_q, out_exp_d;
    logic                  out_zero_q, out_zero_d;
    logic                  out_denorm_q, out_denorm_d;

    logic [SHIFTWIDTH-1:0] lz;
    logic [DATAWIDTH-1:0]  shift_result;

    fp_lshift #(
        .SHIFTWIDTH (SHIFTWIDTH),
        .DATAWIDTH  (DATAWIDTH)
    ) u_lshift (
        .val    (mant_q),
        .count  (sh_q),
        .result (shift_result)
    );

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid) state_d = LZC;
            LZC:     state_d = SHIFT;
            SHIFT:   state_d = HOLD;
            HOLD:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == HOLD);
        busy      = (state_q != IDLE);
    end

    // Priority search from the MSB; a zero mantissa leaves lz at 0 and is flagged separately.
    always_comb begin
        logic found;
        lz    = '0;
        found = 1'b0;
        for (int i = DATAWIDTH - 1; i >= 0; i--) begin
            if (!found && mant_q[i]) begin
                lz    = SHIFTWIDTH'(DATAWIDTH - 1 - i);
                found = 1'b1;
            end
        end
    end

    always_comb begin
        mant_d       = mant_q;
        exp_d        = exp_q;
        sh_d         = sh_q;
        denorm_d     = denorm_q;
        zero_d       = zero_q;
        out_mant_d   = out_mant_q;
        out_exp_d    = out_exp_q;
        out_zero_d   = out_zero_q;
        out_denorm_d = out_denorm_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    mant_d = in_mant;
                    exp_d  = in_exp;
                end
            end
            LZC: begin
                zero_d = (mant_q == '0);
                if (mant_q == '0) begin
                    sh_d     = '0;
                    denorm_d = 1'b0;
                end else if (int'(lz) > int'(exp_q)) begin
                    // Exponent runs out before the leading one reaches the MSB.
                    sh_d     = SHIFTWIDTH'(exp_q);
                    denorm_d = 1'b1;
                end else begin
                    sh_d     = lz;
                    denorm_d = 1'b0;
                end
            end
            SHIFT: begin
                out_mant_d   = shift_result;
                out_exp_d    = zero_q ? '0 : exp_q - EXPWIDTH'(sh_q);
                out_zero_d   = zero_q;
                out_denorm_d = denorm_q;
            end
            default: ;
        endcase
    end

    // NOTE: captured operand and result registers are reset so an aborted operand leaves no trace.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mant_q       <= '0;
            exp_q        <= '0;
            sh_q         <= '0;
            denorm_q     <= 1'b0;
            zero_q       <= 1'b0;
            out_mant_q   <= '0;
            out_exp_q    <= '0;
            out_zero_q   <= 1'b0;
            out_denorm_q <= 1'b0;
        end else begin
            mant_q       <= mant_d;
            exp_q        <= exp_d;
            sh_q         <= sh_d;
            denorm_q     <= denorm_d;
            zero_q       <= zero_d;
            out_mant_q   <= out_mant_d;
            out_exp_q    <= out_exp_d;
            out_zero_q   <= out_zero_d;
            out_denorm_q <= out_denorm_d;
        end
    end

    assign out_mant   = out_mant_q;
    assign out_exp    = out_exp_q;
    assign out_zero   = out_zero_q;
    assign out_denorm = out_denorm_q;

endmodule

// File: tb/tb_fp_norm_ctrl.sv
// Directed and random scoreboard bench for fp_norm_ctrl: expected results are queued at
// drive time and popped when out_valid appears.

module tb_fp_norm_ctrl;

    typedef struct packed {
        logic [22:0] mant;
        logic [7:0]  exp;
        logic        zero;
        logic        denorm;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [22:0] in_mant = '0;
    logic [7:0]  in_exp = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [22:0] out_mant;
    logic [7:0]  out_exp;
    logic        out_zero;
    logic        out_denorm;
    logic        busy;

    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    int   acc_cyc = 0;
    exp_t sb[$];

    fp_norm_ctrl #(
        .DATAWIDTH  (23),
        .SHIFTWIDTH (5),
        .EXPWIDTH   (8)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_mant    (in_mant),
        .in_exp     (in_exp),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_mant   (out_mant),
        .out_exp    (out_exp),
        .out_zero   (out_zero),
        .out_denorm (out_denorm),
        .busy       (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish before 200000");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    function automatic exp_t model(input logic [22:0] m, input logic [7:0] e);
        exp_t r;
        int   lz;
        r  = '0;
        lz = 0;
        if (m == '0) begin
            r.zero = 1'b1;
            return r;
        end
        while (!m[22-lz]) lz++;
        if (lz > int'(e)) begin
            r.mant   = m << e;
            r.exp    = '0;
            r.denorm = 1'b1;
        end else begin
            r.mant = m << lz;
            r.exp  = e - 8'(lz);
        end
        return r;
    endfunction

    // Present an operand, wait (bounded) for in_ready, and complete the acceptance edge.
    task automatic send(input logic [22:0] m, input logic [7:0] e, input bit push, input exp_t x);
        int waited;
        waited   = 0;
        in_mant  = m;
        in_exp   = e;
        in_valid = 1'b1;
        if (push) sb.push_back(x);
        @(negedge clk);
        while (!in_ready && waited < 10) begin
            @(negedge clk);
            waited++;
        end
        check("accept_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        acc_cyc  = cyc;
    endtask

    // Wait for a result, score it, optionally stall for `hold` cycles while offering a new operand.
    task automatic collect(input int hold, input logic [22:0] nm, input logic [7:0] ne);
        int   waited;
        exp_t x;
        waited = 0;
        x      = '0;
        @(negedge clk);
        while (!out_valid && waited < 10) begin
            @(negedge clk);
            waited++;
        end
        check("out_valid_seen", 32'(out_valid), 32'd1);
        check("latency", 32'(cyc - acc_cyc), 32'd2);
        if (sb.size() == 0) begin
            check("sb_nonempty", 32'd0, 32'd1);
        end else begin
            x = sb.pop_front();
            check("out_mant", 32'(out_mant), 32'(x.mant));
            check("out_exp", 32'(out_exp), 32'(x.exp));
            check("out_zero", 32'(out_zero), 32'(x.zero));
            check("out_denorm", 32'(out_denorm), 32'(x.denorm));
        end
        if (hold > 0) begin
            out_ready = 1'b0;
            in_mant   = nm;
            in_exp    = ne;
            in_valid  = 1'b1;
            for (int i = 0; i < hold; i++) begin
                @(negedge clk);
                check("hold_valid", 32'(out_valid), 32'd1);
                check("hold_mant", 32'(out_mant), 32'(x.mant));
                check("hold_exp", 32'(out_exp), 32'(x.exp));
                check("hold_in_ready", 32'(in_ready), 32'd0);
                check("hold_busy", 32'(busy), 32'd1);
            end
            out_ready = 1'b1;
        end
        @(posedge clk);
        #1;
        check("valid_falls", 32'(out_valid), 32'd0);
        check("idle_ready", 32'(in_ready), 32'd1);
    endtask

    initial begin
        logic [22:0] m;
        logic [7:0]  e;
        int          prev_acc;

        // Reset state
        #2 rst_n = 1'b0;
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_mant", 32'(out_mant), 32'd0);
        check("rst_out_exp", 32'(out_exp), 32'd0);
        check("rst_out_zero", 32'(out_zero), 32'd0);
        check("rst_out_denorm", 32'(out_denorm), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_in_ready", 32'(in_ready), 32'd1);
        check("post_rst_busy", 32'(busy), 32'd0);
        out_ready = 1'b1;

        // Directed cases with hand-derived expectations
        send(23'h000001, 8'd100, 1'b1, '{mant: 23'h400000, exp: 8'd78, zero: 1'b0, denorm: 1'b0});
        collect(0, '0, '0);
        send(23'h001000, 8'd4, 1'b1, '{mant: 23'h010000, exp: 8'd0, zero: 1'b0, denorm: 1'b1});
        collect(0, '0, '0);
        send(23'h000000, 8'd55, 1'b1, '{mant: 23'h000000, exp: 8'd0, zero: 1'b1, denorm: 1'b0});
        collect(0, '0, '0);
        send(23'h400000, 8'd9, 1'b1, '{mant: 23'h400000, exp: 8'd9, zero: 1'b0, denorm: 1'b0});
        collect(0, '0, '0);
        send(23'h000010, 8'd0, 1'b1, '{mant: 23'h000010, exp: 8'd0, zero: 1'b0, denorm: 1'b1});
        collect(0, '0, '0);
        send(23'h7fffff, 8'd0, 1'b1, '{mant: 23'h7fffff, exp: 8'd0, zero: 1'b0, denorm: 1'b0});
        collect(0, '0, '0);
        send(23'h000300, 8'd13, 1'b1, '{mant: 23'h600000, exp: 8'd0, zero: 1'b0, denorm: 1'b0});
        collect(0, '0, '0);

        // Backpressure: stall 5 cycles in HOLD while a new operand waits
        send(23'h0000ff, 8'd200, 1'b1, '{mant: 23'h7f8000, exp: 8'd185, zero: 1'b0, denorm: 1'b0});
        collect(5, 23'h020000, 8'd50);
        send(23'h020000, 8'd50, 1'b1, '{mant: 23'h400000, exp: 8'd45, zero: 1'b0, denorm: 1'b0});
        collect(0, '0, '0);

        // Reset during SHIFT discards the operand
        send(23'h000300, 8'd200, 1'b1, '{mant: 23'h600000, exp: 8'd187, zero: 1'b0, denorm: 1'b0});
        collect(0, '0, '0);
        send(23'h000abc, 8'd120, 1'b0, '0);
        @(posedge clk);
        @(negedge clk);
        check("mid_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("abort_out_mant", 32'(out_mant), 32'd0);
        check("abort_out_exp", 32'(out_exp), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("no_valid_after_abort", 32'(out_valid), 32'd0);
        end
        send(23'h000001, 8'd100, 1'b1, '{mant: 23'h400000, exp: 8'd78, zero: 1'b0, denorm: 1'b0});
        collect(0, '0, '0);

        // Back-to-back random operands against the reference model
        prev_acc = 0;
        for (int i = 0; i < 24; i++) begin
            m = 23'($urandom) >> $urandom_range(0, 23);
            e = 8'($urandom_range(0, 255));
            send(m, e, 1'b1, model(m, e));
            if (i > 0) check("throughput", 32'(acc_cyc - prev_acc), 32'd4);
            prev_acc = acc_cyc;
            collect(0, '0, '0);
        end

        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
